arena_store: RTL and testbench

ARENA_STORE -- requirements
Module: arena_store

---
 rtl/life_pkg.sv | 14 +
 rtl/arena_row_mux.sv | 25 ++
 rtl/arena_store.sv | 197 +++++++++++++++++++
 tb/tb_arena_store.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared definitions for the arena storage and the engine blocks around it:
// the arena FSM state type and the width of every row index bus.
package life_pkg;

    // Row indices are one byte wide everywhere, which caps the arena at 256 rows.
    localparam int ROW_IDX_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        SCAN  = 2'd2
    } arena_state_e;

endpackage

// File: rtl/arena_row_mux.sv
// Indexed read of one arena row.
// An index beyond the last row returns all zeros, so callers never need to
// range-check before reading.
module arena_row_mux
    import life_pkg::*;
#(
    parameter int WIDTH  = 10,
    parameter int HEIGHT = 10
) (
    input  logic [WIDTH-1:0]     rows_i [HEIGHT],
    input  logic [ROW_IDX_W-1:0] index_i,
    output logic [WIDTH-1:0]     row_o
);

    // Compare against every legal index; no match leaves the zero default in place.
    always_comb begin
        row_o = '0;
        for (int i = 0; i < HEIGHT; i++) begin
            if (index_i == ROW_IDX_W'(i)) begin
                row_o = rows_i[i];
            end
        end
    end

endmodule

// File: rtl/arena_store.sv
// Arena storage: ARENA_HEIGHT registered rows of ARENA_WIDTH cells, with an
// engine read/write port, a one-row-per-cycle clear and a one-row-per-cycle
// display scan.
// Optional feature: define ARENA_NEIGHBOUR_ROWS_EN to add the toroidal
// above/below neighbour row outputs for the selected row.
module arena_store
    import life_pkg::*;
#(
    parameter int ARENA_WIDTH  = 10,
    parameter int ARENA_HEIGHT = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ROW_IDX_W-1:0]   arena_row_select,
    input  logic [ARENA_WIDTH-1:0] arena_columns_new,
    input  logic                   arena_columns_write,
    output logic [ARENA_WIDTH-1:0] arena_columns,
    input  logic                   clear,
    input  logic                   scan_start,
    output logic                   busy,
    output logic                   scan_valid,
    output logic [ROW_IDX_W-1:0]   scan_row,
    output logic [ARENA_WIDTH-1:0] scan_columns,
    output logic                   scan_last
`ifdef ARENA_NEIGHBOUR_ROWS_EN
    ,
    output logic [ARENA_WIDTH-1:0] arena_columns_above,
    output logic [ARENA_WIDTH-1:0] arena_columns_below
`endif
);

    localparam logic [ROW_IDX_W-1:0] LAST_ROW = ROW_IDX_W'(ARENA_HEIGHT - 1);

    logic [ARENA_WIDTH-1:0] rows_q [ARENA_HEIGHT];
    logic [ARENA_WIDTH-1:0] rows_d [ARENA_HEIGHT];

    arena_state_e           state_q;
    logic [ROW_IDX_W-1:0]   row_cnt_q;
    logic [ROW_IDX_W-1:0]   row_cnt_next;
    logic                   busy_q;
    logic                   scan_valid_q;
    logic [ROW_IDX_W-1:0]   scan_row_q;
    logic [ARENA_WIDTH-1:0] scan_columns_q;
    logic                   scan_last_q;
    logic [ARENA_WIDTH-1:0] scan_row_data;

    // Engine read port: combinational, so it shows the contents before the coming edge.
    arena_row_mux #(
        .WIDTH  (ARENA_WIDTH),
        .HEIGHT (ARENA_HEIGHT)
    ) u_engine_mux (
        .rows_i  (rows_q),
        .index_i (arena_row_select),
        .row_o   (arena_columns)
    );

    // Scan read port: indexed by the shared row counter.
    arena_row_mux #(
        .WIDTH  (ARENA_WIDTH),
        .HEIGHT (ARENA_HEIGHT)
    ) u_scan_mux (
        .rows_i  (rows_q),
        .index_i (row_cnt_q),
        .row_o   (scan_row_data)
    );

    // The row counter wraps back to zero after the last row so IDLE always starts from row 0.
    assign row_cnt_next = (row_cnt_q == LAST_ROW) ? '0 : row_cnt_q + ROW_IDX_W'(1);

    // Next row contents: clearing owns the array; otherwise an in-range engine write lands.
    always_comb begin
        for (int i = 0; i < ARENA_HEIGHT; i++) begin
            rows_d[i] = rows_q[i];
            if (state_q == CLEAR) begin
                if (row_cnt_q == ROW_IDX_W'(i)) begin
                    rows_d[i] = '0;
                end
            end else if (arena_columns_write && (arena_row_select == ROW_IDX_W'(i))) begin
                rows_d[i] = arena_columns_new;
            end
        end
    end

    // Row storage with asynchronous wipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ARENA_HEIGHT; i++) begin
                rows_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ARENA_HEIGHT; i++) begin
                rows_q[i] <= rows_d[i];
            end
        end
    end

    // Control FSM with registered busy and scan outputs; row 0 is emitted on the start edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            row_cnt_q      <= '0;
            busy_q         <= 1'b0;
            scan_valid_q   <= 1'b0;
            scan_row_q     <= '0;
            scan_columns_q <= '0;
            scan_last_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (clear) begin
                        state_q   <= CLEAR;
                        busy_q    <= 1'b1;
                        row_cnt_q <= '0;
                    end else if (scan_start) begin
                        state_q        <= SCAN;
                        busy_q         <= 1'b1;
                        scan_valid_q   <= 1'b1;
                        scan_row_q     <= row_cnt_q;
                        scan_columns_q <= scan_row_data;
                        scan_last_q    <= (row_cnt_q == LAST_ROW);
                        row_cnt_q      <= row_cnt_next;
                    end
                end
                CLEAR: begin
                    row_cnt_q <= row_cnt_next;
                    if (row_cnt_q == LAST_ROW) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                SCAN: begin
                    if (scan_last_q) begin
                        state_q        <= IDLE;
                        busy_q         <= 1'b0;
                        scan_valid_q   <= 1'b0;
                        scan_row_q     <= '0;
                        scan_columns_q <= '0;
                        scan_last_q    <= 1'b0;
                    end else begin
                        scan_row_q     <= row_cnt_q;
                        scan_columns_q <= scan_row_data;
                        scan_last_q    <= (row_cnt_q == LAST_ROW);
                        row_cnt_q      <= row_cnt_next;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    row_cnt_q <= '0;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign scan_valid   = scan_valid_q;
    assign scan_row     = scan_row_q;
    assign scan_columns = scan_columns_q;
    assign scan_last    = scan_last_q;

`ifdef ARENA_NEIGHBOUR_ROWS_EN
    logic [ROW_IDX_W-1:0]   above_idx;
    logic [ROW_IDX_W-1:0]   below_idx;
    logic [ARENA_WIDTH-1:0] above_data;
    logic [ARENA_WIDTH-1:0] below_data;
    logic                   select_in_range;

    // Toroidal neighbour indices: row 0 looks up to the last row, the last row looks down to row 0.
    always_comb begin
        above_idx       = (arena_row_select == '0) ? LAST_ROW : arena_row_select - ROW_IDX_W'(1);
        below_idx       = (arena_row_select == LAST_ROW) ? '0 : arena_row_select + ROW_IDX_W'(1);
        select_in_range = (arena_row_select <= LAST_ROW);
    end

    arena_row_mux #(
        .WIDTH  (ARENA_WIDTH),
        .HEIGHT (ARENA_HEIGHT)
    ) u_above_mux (
        .rows_i  (rows_q),
        .index_i (above_idx),
        .row_o   (above_data)
    );

    arena_row_mux #(
        .WIDTH  (ARENA_WIDTH),
        .HEIGHT (ARENA_HEIGHT)
    ) u_below_mux (
        .rows_i  (rows_q),
        .index_i (below_idx),
        .row_o   (below_data)
    );

    assign arena_columns_above = select_in_range ? above_data : '0;
    assign arena_columns_below = select_in_range ? below_data : '0;
`endif

endmodule

// File: tb/tb_arena_store.sv
// Self-checking bench for arena_store (10 x 10 arena).
// Rows are modelled as a plain array; scans are checked against a snapshot of it.
module tb_arena_store;

    localparam int W = 10;
    localparam int H = 10;

    logic         clk;
    logic         rst_n;
    logic [7:0]   arena_row_select;
    logic [W-1:0] arena_columns_new;
    logic         arena_columns_write;
    logic [W-1:0] arena_columns;
    logic         clear;
    logic         scan_start;
    logic         busy;
    logic         scan_valid;
    logic [7:0]   scan_row;
    logic [W-1:0] scan_columns;
    logic         scan_last;
`ifdef ARENA_NEIGHBOUR_ROWS_EN
    logic [W-1:0] arena_columns_above;
    logic [W-1:0] arena_columns_below;
`endif

    int checkCount = 0;
    int errCount   = 0;

    logic [W-1:0] model [H];

    typedef struct {
        logic [7:0]   sel;
        logic [W-1:0] data;
        logic         wr;
        logic [W-1:0] expCols;
    } vec_t;

    vec_t vecs [10];

    arena_store #(
        .ARENA_WIDTH  (W),
        .ARENA_HEIGHT (H)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .arena_row_select    (arena_row_select),
        .arena_columns_new   (arena_columns_new),
        .arena_columns_write (arena_columns_write),
        .arena_columns       (arena_columns),
        .clear               (clear),
        .scan_start          (scan_start),
        .busy                (busy),
        .scan_valid          (scan_valid),
        .scan_row            (scan_row),
        .scan_columns        (scan_columns),
        .scan_last           (scan_last)
`ifdef ARENA_NEIGHBOUR_ROWS_EN
        ,
        .arena_columns_above (arena_columns_above),
        .arena_columns_below (arena_columns_below)
`endif
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act !== exp) begin
            errCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs just after the falling edge; outputs are then sampled mid-cycle.
    task automatic applyStimulus(input logic [7:0] sel, input logic [W-1:0] data, input logic wr,
                                 input logic clr, input logic scn);
        @(negedge clk);
        arena_row_select    = sel;
        arena_columns_new   = data;
        arena_columns_write = wr;
        clear               = clr;
        scan_start          = scn;
        #1;
    endtask

    function automatic logic [W-1:0] modelRead(input logic [7:0] sel);
        if (sel < 8'(H)) return model[sel];
        return '0;
    endfunction

    task automatic modelWrite(input logic [7:0] sel, input logic [W-1:0] data, input logic wr);
        if (wr && sel < 8'(H)) model[sel] = data;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_busy"}, {31'd0, busy}, 32'd0);
        checkOutput({tag, "_valid"}, {31'd0, scan_valid}, 32'd0);
        checkOutput({tag, "_last"}, {31'd0, scan_last}, 32'd0);
        checkOutput({tag, "_row"}, {24'd0, scan_row}, 32'd0);
        checkOutput({tag, "_cols"}, {22'd0, scan_columns}, 32'd0);
    endtask

    // Full scan against a snapshot of the model; optionally pokes the FSM mid-scan.
    task automatic runScan(input bit inject);
        logic [W-1:0] snap [H];
        for (int r = 0; r < H; r++) snap[r] = model[r];
        applyStimulus(8'd0, '0, 1'b0, 1'b0, 1'b1);
        checkOutput("scan_pre_valid", {31'd0, scan_valid}, 32'd0);
        for (int b = 0; b < H; b++) begin
            if (inject && b == 3) applyStimulus(8'd0, '0, 1'b0, 1'b0, 1'b1);
            else if (inject && b == 5) applyStimulus(8'd0, '0, 1'b0, 1'b1, 1'b0);
            else if (inject && b == 6) applyStimulus(8'd7, 10'h3C3, 1'b1, 1'b0, 1'b0);
            else applyStimulus(8'd0, '0, 1'b0, 1'b0, 1'b0);
            checkOutput("scan_valid", {31'd0, scan_valid}, 32'd1);
            checkOutput("scan_row", {24'd0, scan_row}, b);
            checkOutput("scan_cols", {22'd0, scan_columns}, {22'd0, snap[b]});
            checkOutput("scan_last", {31'd0, scan_last}, (b == H - 1) ? 32'd1 : 32'd0);
            checkOutput("scan_busy", {31'd0, busy}, 32'd1);
            if (inject && b == 6) modelWrite(8'd7, 10'h3C3, 1'b1);
        end
        applyStimulus(8'd7, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("scan_end_valid", {31'd0, scan_valid}, 32'd0);
        checkOutput("scan_end_busy", {31'd0, busy}, 32'd0);
        checkOutput("scan_end_read", {22'd0, arena_columns}, {22'd0, modelRead(8'd7)});
        applyStimulus(8'd0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("scan_no_restart", {31'd0, scan_valid}, 32'd0);
    endtask

    initial begin
        rst_n               = 1'b0;
        arena_row_select    = '0;
        arena_columns_new   = '0;
        arena_columns_write = 1'b0;
        clear               = 1'b0;
        scan_start          = 1'b0;
        for (int r = 0; r < H; r++) model[r] = '0;

        // Reset state
        #2;
        checkAllZero("reset");
        checkOutput("reset_read", {22'd0, arena_columns}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven engine read/write vectors
        vecs[0] = '{8'd3,   10'h2AA, 1'b1, 10'h000};
        vecs[1] = '{8'd3,   10'h000, 1'b0, 10'h2AA};
        vecs[2] = '{8'd2,   10'h000, 1'b0, 10'h000};
        vecs[3] = '{8'd4,   10'h000, 1'b0, 10'h000};
        vecs[4] = '{8'd12,  10'h3FF, 1'b1, 10'h000};
        vecs[5] = '{8'd12,  10'h000, 1'b0, 10'h000};
        vecs[6] = '{8'd3,   10'h000, 1'b0, 10'h2AA};
        vecs[7] = '{8'd255, 10'h155, 1'b1, 10'h000};
        vecs[8] = '{8'd9,   10'h155, 1'b1, 10'h000};
        vecs[9] = '{8'd9,   10'h000, 1'b0, 10'h155};
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].sel, vecs[i].data, vecs[i].wr, 1'b0, 1'b0);
            checkOutput("table_read", {22'd0, arena_columns}, {22'd0, vecs[i].expCols});
            modelWrite(vecs[i].sel, vecs[i].data, vecs[i].wr);
        end
        for (int r = 0; r < H; r++) begin
            applyStimulus(8'(r), '0, 1'b0, 1'b0, 1'b0);
            checkOutput("table_row_state", {22'd0, arena_columns}, {22'd0, modelRead(8'(r))});
        end

        // Clear: fill everything, then busy for exactly H cycles with writes dropped
        for (int r = 0; r < H; r++) begin
            applyStimulus(8'(r), 10'h3FF, 1'b1, 1'b0, 1'b0);
            modelWrite(8'(r), 10'h3FF, 1'b1);
        end
        applyStimulus(8'd0, '0, 1'b0, 1'b1, 1'b0);
        checkOutput("clear_pre_busy", {31'd0, busy}, 32'd0);
        for (int k = 0; k < H; k++) begin
            applyStimulus(8'd0, 10'h123, 1'b1, 1'b0, 1'b0);
            checkOutput("clear_busy", {31'd0, busy}, 32'd1);
        end
        applyStimulus(8'd0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("clear_done_busy", {31'd0, busy}, 32'd0);
        for (int r = 0; r < H; r++) model[r] = '0;
        for (int r = 0; r < H; r++) begin
            applyStimulus(8'(r), '0, 1'b0, 1'b0, 1'b0);
            checkOutput("clear_row_zero", {22'd0, arena_columns}, 32'd0);
        end

        // Scan with row n holding n, plus ignored start/clear and a same-edge write
        for (int r = 0; r < H; r++) begin
            applyStimulus(8'(r), 10'(r), 1'b1, 1'b0, 1'b0);
            modelWrite(8'(r), 10'(r), 1'b1);
        end
        runScan(1'b1);

        // Reset at scan beat 4 aborts everything immediately
        applyStimulus(8'd9, '0, 1'b0, 1'b0, 1'b1);
        for (int b = 0; b <= 4; b++) applyStimulus(8'd9, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("abort_beat", {24'd0, scan_row}, 32'd4);
        rst_n = 1'b0;
        #1;
        checkAllZero("abort");
        checkOutput("abort_read", {22'd0, arena_columns}, 32'd0);
        for (int r = 0; r < H; r++) model[r] = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(8'd0, '0, 1'b0, 1'b0, 1'b0);
            checkOutput("abort_no_valid", {31'd0, scan_valid}, 32'd0);
        end

        // Randomized engine traffic against the model, then a scan of the result
        for (int k = 0; k < 150; k++) begin
            logic [7:0]   sel;
            logic [W-1:0] data;
            logic         wr;
            sel  = 8'($urandom_range(0, 13));
            data = W'($urandom);
            wr   = 1'($urandom_range(0, 1));
            applyStimulus(sel, data, wr, 1'b0, 1'b0);
            checkOutput("rand_read", {22'd0, arena_columns}, {22'd0, modelRead(sel)});
            modelWrite(sel, data, wr);
        end
        runScan(1'b0);

`ifdef ARENA_NEIGHBOUR_ROWS_EN
        // Toroidal neighbours around row 0 and the last row
        applyStimulus(8'd9, 10'h201, 1'b1, 1'b0, 1'b0);
        modelWrite(8'd9, 10'h201, 1'b1);
        applyStimulus(8'd1, 10'h0F0, 1'b1, 1'b0, 1'b0);
        modelWrite(8'd1, 10'h0F0, 1'b1);
        applyStimulus(8'd0, 10'h00F, 1'b1, 1'b0, 1'b0);
        modelWrite(8'd0, 10'h00F, 1'b1);
        applyStimulus(8'd0, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("nb_above_row0", {22'd0, arena_columns_above}, {22'd0, model[9]});
        checkOutput("nb_below_row0", {22'd0, arena_columns_below}, {22'd0, model[1]});
        applyStimulus(8'd9, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("nb_below_row9", {22'd0, arena_columns_below}, {22'd0, model[0]});
        checkOutput("nb_above_row9", {22'd0, arena_columns_above}, {22'd0, model[8]});
        applyStimulus(8'd12, '0, 1'b0, 1'b0, 1'b0);
        checkOutput("nb_above_oor", {22'd0, arena_columns_above}, 32'd0);
        checkOutput("nb_below_oor", {22'd0, arena_columns_below}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
        $finish;
    end

endmodule
